// File: rtl/fp_result_packer.sv
// rtl/fp_result_packer.sv - packs normalized FP triples into IEEE-754 words behind a small output FIFO
// Optional head-word classification and sticky Inf/NaN flags are compiled in with FP_PACK_STATUS_EN.
module fp_result_packer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       normalizedSign,
    input  logic [7:0]                 normalizedExponent,
    input  logic [22:0]                normalizedMantissa,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                Result,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clear_flags,
    output logic                       flagZero,
    output logic                       flagInf,
    output logic                       flagNaN,
    output logic                       flagDenorm,
    output logic                       stickyInf,
    output logic                       stickyNaN
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   in_word;
    logic          push, pop, head_from_input;

    assign in_word   = {normalizedSign, normalizedExponent, normalizedMantissa};
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign Result    = result_q;
    assign count     = count_q;

    // Result is a dedicated register holding the next head, so it only moves on
    // an edge and keeps the last popped word once the FIFO drains.
    assign head_from_input = (count_q == '0) || (pop && count_q == CW'(1));

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        result_d = result_q;
        if (count_d != '0) begin
            if (head_from_input)
                result_d = in_word;
            else
                result_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_word;
    end

`ifdef FP_PACK_STATUS_EN
    logic exp_zero, exp_ones, frac_zero;
    logic sticky_inf_q, sticky_inf_d;
    logic sticky_nan_q, sticky_nan_d;

    assign exp_zero  = (result_q[30:23] == 8'h00);
    assign exp_ones  = (result_q[30:23] == 8'hFF);
    assign frac_zero = (result_q[22:0] == 23'h0);

    assign flagZero   = out_valid & exp_zero & frac_zero;
    assign flagInf    = out_valid & exp_ones & frac_zero;
    assign flagNaN    = out_valid & exp_ones & ~frac_zero;
    assign flagDenorm = out_valid & exp_zero & ~frac_zero;

    // A set in the same cycle as clear_flags takes priority.
    always_comb begin
        sticky_inf_d = (sticky_inf_q & ~clear_flags) | (pop & flagInf);
        sticky_nan_d = (sticky_nan_q & ~clear_flags) | (pop & flagNaN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_inf_q <= 1'b0;
            sticky_nan_q <= 1'b0;
        end else begin
            sticky_inf_q <= sticky_inf_d;
            sticky_nan_q <= sticky_nan_d;
        end
    end

    assign stickyInf = sticky_inf_q;
    assign stickyNaN = sticky_nan_q;
`else
    logic unused_clear_flags;
    assign unused_clear_flags = clear_flags;

    assign flagZero   = 1'b0;
    assign flagInf    = 1'b0;
    assign flagNaN    = 1'b0;
    assign flagDenorm = 1'b0;
    assign stickyInf  = 1'b0;
    assign stickyNaN  = 1'b0;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// tb/tb_fp_result_packer.sv - directed self-checking bench for fp_result_packer
module tb_fp_result_packer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        normalizedSign;
    logic [7:0]  normalizedExponent;
    logic [22:0] normalizedMantissa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [2:0]  count;
    logic        clear_flags;
    logic        flagZero, flagInf, flagNaN, flagDenorm;
    logic        stickyInf, stickyNaN;

    int total = 0;
    int bad   = 0;

    logic [31:0] fill_w   [5];
    logic [31:0] stream_w [8];

    fp_result_packer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .normalizedSign     (normalizedSign),
        .normalizedExponent (normalizedExponent),
        .normalizedMantissa (normalizedMantissa),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .Result             (Result),
        .count              (count),
        .clear_flags        (clear_flags),
        .flagZero           (flagZero),
        .flagInf            (flagInf),
        .flagNaN            (flagNaN),
        .flagDenorm         (flagDenorm),
        .stickyInf          (stickyInf),
        .stickyNaN          (stickyNaN)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [31:0] w);
        in_valid           = 1'b1;
        normalizedSign     = w[31];
        normalizedExponent = w[30:23];
        normalizedMantissa = w[22:0];
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_flags = 1'b0;
        normalizedSign = 1'b0;
        normalizedExponent = 8'h0;
        normalizedMantissa = 23'h0;

        fill_w[0] = 32'h3F800000;
        fill_w[1] = 32'hC0490FDB;
        fill_w[2] = 32'h00000000;
        fill_w[3] = 32'h7F7FFFFF;
        fill_w[4] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++)
            stream_w[i] = 32'h41000000 + 32'(i) * 32'h00100003;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", Result, 32'h0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_flags", {26'h0, flagZero, flagInf, flagNaN, flagDenorm, stickyInf, stickyNaN}, 32'h0);

        // single word, one-cycle latency
        drive_word(32'h3F800000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("one_valid", 32'(out_valid), 32'd1);
        check_eq("one_result", Result, 32'h3F800000);
        check_eq("one_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("one_drained_valid", 32'(out_valid), 32'd0);
        check_eq("one_drained_count", 32'(count), 32'd0);
        check_eq("one_hold_result", Result, 32'h3F800000);

        // fill to full, then a rejected push alongside a pop
        for (int i = 0; i < 4; i++) begin
            drive_word(fill_w[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_head", Result, fill_w[0]);
        drive_word(fill_w[4]);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("full_pop_count", 32'(count), 32'd3);
        check_eq("full_pop_head", Result, fill_w[1]);
        check_eq("full_pop_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            check_eq("drain_head", Result, fill_w[i]);
            check_eq("drain_count", 32'(count), 32'(4 - i));
        end
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("drain_empty_count", 32'(count), 32'd0);
        check_eq("drain_empty_result", Result, fill_w[3]);

        // streaming with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_word(stream_w[i]);
            @(negedge clk);
            check_eq("stream_result", Result, stream_w[i]);
            check_eq("stream_count", 32'(count), 32'd1);
            check_eq("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("stream_end_count", 32'(count), 32'd0);
        check_eq("stream_end_result", Result, stream_w[7]);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            drive_word(fill_w[i + 1]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("pre_arst_count", 32'(count), 32'd3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_result", Result, 32'h0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive_word(32'hC2F60000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("post_arst_result", Result, 32'hC2F60000);
        check_eq("post_arst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_arst_drained", 32'(count), 32'd0);

`ifdef FP_PACK_STATUS_EN
        drive_word(32'h7FC00000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("nan_flag", 32'(flagNaN), 32'd1);
        check_eq("nan_not_inf", 32'(flagInf), 32'd0);
        check_eq("nan_sticky_before", 32'(stickyNaN), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("nan_sticky_after", 32'(stickyNaN), 32'd1);
        check_eq("nan_flag_empty", 32'(flagNaN), 32'd0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check_eq("nan_sticky_cleared", 32'(stickyNaN), 32'd0);

        drive_word(32'hFF800000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("inf_flag", 32'(flagInf), 32'd1);
        out_ready = 1'b1;
        clear_flags = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear_flags = 1'b0;
        check_eq("inf_set_beats_clear", 32'(stickyInf), 32'd1);

        drive_word(32'h80000000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("zero_flag", 32'(flagZero), 32'd1);
        check_eq("zero_not_denorm", 32'(flagDenorm), 32'd0);
        out_ready = 1'b1;
        drive_word(32'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("denorm_flag", 32'(flagDenorm), 32'd1);
        check_eq("denorm_not_zero", 32'(flagZero), 32'd0);
        check_eq("denorm_result", Result, 32'h00000001);
        @(negedge clk);
        out_ready = 1'b0;
`else
        drive_word(32'h7FC00000);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("off_flags_head", {28'h0, flagZero, flagInf, flagNaN, flagDenorm}, 32'h0);
        out_ready = 1'b1;
        clear_flags = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear_flags = 1'b0;
        check_eq("off_sticky", {30'h0, stickyInf, stickyNaN}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
